// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: data-hazard unit that sits beside the decode stage.
// It keeps a shift register with one record {valid, rd, is_load} for each of
// DEPTH downstream stages. Stage 1 is the youngest and stage DEPTH the oldest.
// From those records it works out, for the instruction in decode:
//   - forwarding selects for rs and rt,
//   - a load-use stall,
//   - a saturating count of stall cycles.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              pipeline advance; 0 freezes every register
//   flush           decode instruction is squashed this cycle
//   instr_d[31:0]   instruction currently in decode
//   stall           hold PC/IF/ID and insert a bubble (combinational)
//   fwd_a, fwd_b    0 = register file, k = result of record in stage k
//   stall_cnt[15:0] saturating count of stall cycles (registered)
module hazard_scoreboard #(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned FW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic [31:0]   instr_d,
  output logic          stall,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [15:0]   stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } rec_t;

  rec_t stage_q [1:DEPTH];
  rec_t stage_d [1:DEPTH];

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  rec_t       dec_rec;
  logic       use_rs;
  logic       use_rt;
  logic       hazard;
  logic       unused_instr_bits;

  assign opcode = instr_d[31:26];
  assign rs     = instr_d[25:21];
  assign rt     = instr_d[20:16];

  // Shamt/funct and immediate bits play no part in hazard detection.
  assign unused_instr_bits = ^instr_d[10:0];

  // Decode the destination record and which source operands are read.
  always_comb begin
    dec_rec = '0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_rec.rd    = instr_d[15:11];
        dec_rec.valid = (instr_d[15:11] != 5'd0);
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OP_LW: begin
        dec_rec.rd      = instr_d[20:16];
        dec_rec.valid   = (instr_d[20:16] != 5'd0);
        dec_rec.is_load = 1'b1;
        use_rs          = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: begin
        use_rs = 1'b0;
        use_rt = 1'b0;
      end
    endcase
  end

  // Per-stage match logic, chained from the oldest stage towards stage 1 so
  // that the youngest matching writer overrides any older one. $0 never
  // matches because records writing $0 are stored invalid.
  genvar k;
  for (k = 1; k <= int'(DEPTH); k++) begin : g_match
    localparam bit EARLY = (k < int'(LOAD_LAT));
    logic          hit_a;
    logic          hit_b;
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;
    logic          ld_a;
    logic          ld_b;
    logic [FW-1:0] older_sel_a;
    logic [FW-1:0] older_sel_b;
    logic          older_ld_a;
    logic          older_ld_b;

    if (k == int'(DEPTH)) begin : g_tail
      assign older_sel_a = '0;
      assign older_sel_b = '0;
      assign older_ld_a  = 1'b0;
      assign older_ld_b  = 1'b0;
    end else begin : g_link
      assign older_sel_a = g_match[k+1].sel_a;
      assign older_sel_b = g_match[k+1].sel_b;
      assign older_ld_a  = g_match[k+1].ld_a;
      assign older_ld_b  = g_match[k+1].ld_b;
    end

    assign hit_a = use_rs && stage_q[k].valid && (stage_q[k].rd == rs);
    assign hit_b = use_rt && stage_q[k].valid && (stage_q[k].rd == rt);
    assign sel_a = hit_a ? FW'(k) : older_sel_a;
    assign sel_b = hit_b ? FW'(k) : older_sel_b;
    // A load still earlier than LOAD_LAT has no forwardable result yet.
    assign ld_a  = hit_a ? (stage_q[k].is_load & EARLY) : older_ld_a;
    assign ld_b  = hit_b ? (stage_q[k].is_load & EARLY) : older_ld_b;
  end

  assign fwd_a  = g_match[1].sel_a;
  assign fwd_b  = g_match[1].sel_b;
  assign hazard = g_match[1].ld_a | g_match[1].ld_b;
  assign stall  = hazard & ~flush;

  // Next record set: a bubble enters stage 1 on stall or flush.
  assign stage_d[1] = (stall || flush) ? rec_t'('0) : dec_rec;
  for (k = 2; k <= int'(DEPTH); k++) begin : g_shift
    assign stage_d[k] = stage_q[k-1];
  end

  // Record shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '{default: rec_t'('0)};
    end else if (en) begin
      stage_q <= stage_d;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (en && stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the pipelined MIPS core, sitting beside the decode stage. It keeps a shift-register record of the destination register of every instruction in flight across DEPTH downstream stages. For the instruction in decode it produces per-operand forwarding selects, a load-use stall and a saturating stall counter. It generalises the fixed distance-1/distance-2 conflict checks to any depth, with register-$0 suppression, youngest-writer priority, bubble insertion and flush.

## Interface
- DEPTH, 3: number of tracked downstream stages (stage 1 = youngest, e.g. EX; stage DEPTH = oldest, e.g. WB); legal 1..7
- LOAD_LAT, 2: lowest stage index at which a load's result is forwardable; legal 1..DEPTH
- FW, 3: width of forwarding selects; must satisfy 2^FW > DEPTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  pipeline advance; 0 freezes all state
- flush  in  1  decode instruction is squashed this cycle
- instr_d  in  32  instruction currently in decode
- stall  out  1  hold PC/IF/ID and insert bubble
- fwd_a  out  FW  source for rs: 0 = register file, k = result of record in stage k
- fwd_b  out  FW  source for rt, same encoding
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Decode of instr_d, by opcode [31:26]:
  - 000000 (R-R ALU): dest = [15:11]; sources rs = [25:21], rt = [20:16]
  - 100011 (lw): dest = [20:16], marked load; source rs
  - 101011 (sw): no dest; sources rs, rt
  - 000100 (beq): no dest; sources rs, rt
  - any other opcode: no dest, no sources
- Record = {valid, rd[4:0], is_load}. A dest of $0 gives valid = 0. $0 is never forwarded and never stalls.
- Operand match: the lowest k in 1..DEPTH with stage[k].valid and stage[k].rd == source.
  - No match, or operand unused: select = 0.
- Hazard: any used source whose matching stage k has is_load = 1 and k < LOAD_LAT.
- stall = hazard & ~flush. During stall, fwd_a/fwd_b still show the match index and are don't-care downstream.
- Unused operand: select forced to 0 (e.g. rt of lw).
- stall, fwd_a and fwd_b are combinational from registered records and instr_d/flush. They have no registered delay.
- On a rising edge with en = 1:
  - stage[k] <= stage[k-1] for k = 2..DEPTH; the old stage[DEPTH] is dropped (already committed to the register file).
  - stage[1] <= bubble (valid = 0) if stall or flush, else record(instr_d).
  - stall_cnt <= stall_cnt + 1 if stall and stall_cnt != 16'hFFFF.
- On a rising edge with en = 0: every register holds, including stall_cnt.

## Timing
- rst asserted, at any time including mid-stall: all records go invalid and stall_cnt = 0 immediately (asynchronous). Outputs then read stall = 0, fwd_a = fwd_b = 0.
- Forward latency is 0 cycles. A writer decoded in cycle n appears in stage 1 in cycle n+1 and in stage k in cycle n+k, if en stays 1.
- Load-use with LOAD_LAT = L: a dependent instruction directly behind a load stalls L-1 cycles, then sees fwd = L.
- Simultaneous flush and hazard: no stall; a bubble is inserted.
- Two writers of the same rd in flight: the younger (lower k) wins.
- A write older than stage DEPTH gives fwd = 0.

## Test plan
- Forward from stage 1: 00221820 (add $3,$1,$2), then 00652022 (sub $4,$3,$5) -> fwd_a = 1, fwd_b = 0, stall = 0. One cycle later, with a nop (00000000) in decode, re-presenting 00652022 -> fwd_a = 2.
- Load-use (DEPTH = 3, LOAD_LAT = 2): 8D280000 (lw $8,0($9)), then 01085020 (add $10,$8,$8):
  - first cycle: stall = 1, stall_cnt 0 -> 1
  - next cycle: stall = 0, fwd_a = fwd_b = 2
  - stage 1 holds a bubble
- $0 suppression: 00220020 (add $0,$1,$2), then 00002820 (add $5,$0,$0) -> fwd_a = fwd_b = 0, stall = 0.
- Priority and flush: 00221820, then 00811820 (both write $3), then 00652022 -> fwd_a = 1. Repeat with flush = 1 on the second instruction -> fwd_a = 2.
- en = 0 for 3 cycles with the load-use pair pending -> stall stays 1, stall_cnt unchanged, records frozen.
- Reset mid-stall -> stall drops without waiting for a clock edge, stall_cnt = 0. Preset stall_cnt to FFFF via 65535 stall cycles -> stays at FFFF.
